ysyx_25060170_fetch_ctrl: RTL

//   Multi-cycle fetch/execute sequencer for the NPC core. Issues the instruction-memory request for the

---
 rtl/ysyx_25060170_fetch_ctrl_pkg.sv | 30 +++
 rtl/ysyx_25060170_wdog_cnt.sv | 31 +++
 rtl/ysyx_25060170_fetch_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_fetch_ctrl_pkg.sv
// Shared types for the NPC fetch/execute sequencer: FSM state encoding,
// fault cause codes, default timing parameters and a small state helper.
package ysyx_25060170_fetch_ctrl_pkg;

   localparam int DEF_TIMEOUT_CYCLES = 256;
   localparam int DEF_CNT_W          = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RSP   = 3'd2,
      S_DISP  = 3'd3,
      S_EXEC  = 3'd4,
      S_UPD   = 3'd5,
      S_FAULT = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_BUSERR   = 2'b10,
      FC_TIMEOUT  = 2'b11
   } fcause_e;

   // States in which the memory handshake is awaited and the watchdog runs.
   function automatic logic is_wait_state(state_e s);
      return (s == S_REQ) || (s == S_RSP);
   endfunction

endpackage

// File: rtl/ysyx_25060170_wdog_cnt.sv
// Watchdog counter: counts enabled cycles, clears on request, and flags the
// cycle in which the count has reached LIMIT-1.
module ysyx_25060170_wdog_cnt
   import ysyx_25060170_fetch_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count waiting cycles; clear has priority so a state change restarts the window.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ysyx_25060170_fetch_ctrl.sv
// Multi-cycle fetch/execute sequencer: fetches the word at pc, hands it to
// the IDU, waits for the EXU, then pulses pc_wen. Misaligned PC, bus errors
// and handshake timeouts park the core in a sticky fault state.
module ysyx_25060170_fetch_ctrl
   import ysyx_25060170_fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        halt,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   output logic [31:0] inst,
   input  logic        inst_ready,
   input  logic        exu_done,
   output logic        pc_wen,
   output logic        busy,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic        fault_q, fault_d;
   fcause_e     cause_q, cause_d;

   logic        wd_clr;
   logic        wd_en;
   logic        wd_expired;

   // The watchdog only runs while parked in a waiting state; any transition restarts it.
   assign wd_en  = is_wait_state(state_q) && (state_d == state_q);
   assign wd_clr = !wd_en;

   ysyx_25060170_wdog_cnt #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   // State, instruction and fault registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Next-state and handshake outputs; a handshake seen in the expiry cycle beats the timeout.
   always_comb begin
      state_d        = state_q;
      inst_d         = inst_q;
      fault_d        = fault_q;
      cause_d        = cause_q;
      imem_req_valid = 1'b0;
      imem_req_addr  = '0;
      inst_valid     = 1'b0;
      pc_wen         = 1'b0;
      busy           = (state_q != S_IDLE) && (state_q != S_FAULT);

      case (state_q)
         S_IDLE: begin
            if (!halt) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            imem_req_addr = pc;
            if (pc[1:0] != 2'b00) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               cause_d = FC_MISALIGN;
            end else begin
               imem_req_valid = 1'b1;
               if (imem_req_ready) begin
                  state_d = S_RSP;
               end else if (wd_expired) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
                  cause_d = FC_TIMEOUT;
               end
            end
         end
         S_RSP: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
                  cause_d = FC_BUSERR;
               end else begin
                  inst_d  = imem_rsp_data;
                  state_d = S_DISP;
               end
            end else if (wd_expired) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               cause_d = FC_TIMEOUT;
            end
         end
         S_DISP: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exu_done) begin
               state_d = S_UPD;
            end
         end
         S_UPD: begin
            pc_wen  = 1'b1;
            state_d = halt ? S_IDLE : S_REQ;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign inst        = inst_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;

endmodule
